ram_dump_tx: RTL and testbench
==============================

Name: ram_dump_tx

Overview:
Readback counterpart of the UART software-upgrade path. The upgrade path writes RAM from UART; this block reads a range of RAM words and streams them out through the uart_mgr TX byte interface. Each word is sent as 4 bytes, little-endian, framed by a header byte and an optional checksum byte. It sits in soc beside uart_mgr, reads through the shared RAM port A mux, and is used for boot verification and debug dumps.

Parameters:
XLEN, 32, RAM data width; must be 32.
RAM_ADDR_LEN, 14, RAM word address width.
HDR_BYTE, 8'hA5, frame header byte sent before any data.
SEND_CKSUM, 1, 1 = append 8-bit checksum after the data; 0 = omit it.

Ports:
clk  in  1  system clock
rstb  in  1  synchronous active-low reset, sampled on the rising edge of clk
start  in  1  one-cycle request to begin a dump; ignored while busy
abort  in  1  terminates the dump; no done pulse
start_addr  in  RAM_ADDR_LEN  first word address; sampled on an accepted start
word_cnt  in  RAM_ADDR_LEN+1  number of words to send; sampled on an accepted start
busy  out  1  high from the cycle after an accepted start until return to IDLE
done  out  1  one-cycle pulse on normal completion
ram_rd_en  out  1  RAM read enable
ram_addr  out  RAM_ADDR_LEN  RAM word address
ram_rd_data  in  XLEN  RAM read data, valid 1 cycle after ram_rd_en
uart_wr_en  out  1  TX byte valid
uart_wr_data  out  8  TX byte
uart_wr_ready  in  1  TX accepts a byte

Behaviour:
- Reset (rstb=0 at a clk edge): every output is 0, FSM goes to IDLE, and the checksum, counters and shift register clear. Reset mid-dump behaves the same; a partially sent frame is not resumed.
- UART handshake:
  - A byte transfers on each cycle where uart_wr_en=1 and uart_wr_ready=1.
  - While uart_wr_en=1 and no transfer occurs, uart_wr_data is held stable.
  - After a transfer, uart_wr_en deasserts for at least 1 cycle before the next byte. This matches the registered ready in the soc IO path.
- FSM states: IDLE, HDR, RD, RDW, SEND, CKS, FIN.
  - IDLE: start=1 latches addr<=start_addr, remaining<=word_cnt, cksum<=0, then goes to HDR.
  - HDR: presents HDR_BYTE. On transfer: go to RD if remaining!=0, else go to CKS (SEND_CKSUM=1) or FIN (SEND_CKSUM=0).
  - RD: ram_rd_en=1 and ram_addr=addr for exactly 1 cycle, then go to RDW.
  - RDW: captures ram_rd_data into a 32-bit shift register, sets byte_idx=0, then goes to SEND.
  - SEND: uart_wr_data = shift[7:0].
    - On each transfer: shift>>=8, cksum+=byte (mod 256), byte_idx++.
    - After byte_idx 3 transfers: addr+=1 (wraps modulo 2^RAM_ADDR_LEN) and remaining-=1.
    - Next state: RD if remaining!=0, else CKS or FIN by SEND_CKSUM.
  - CKS: presents cksum, which is the sum of data bytes only (header excluded). On transfer, go to FIN.
  - FIN: done=1 for 1 cycle, busy=0, then go to IDLE.
- busy=1 in every state except IDLE and FIN.
- ram_rd_en=0 outside RD. ram_addr holds its last value when not reading.
- Throughput: the RD/RDW cost 2 cycles per word, plus UART back-pressure.
- abort=1 in any non-IDLE state returns to IDLE on the next edge.
  - uart_wr_en drops; a byte transferred in the same cycle counts as sent.
  - No done pulse.
  - abort has priority over a same-cycle completion.
- start while busy is ignored and does not queue. start and abort both high in IDLE: abort wins and the start is ignored.
- word_cnt = 2^RAM_ADDR_LEN dumps the whole RAM. A larger word_cnt wraps through the address space and continues counting.

Decomposition:
- Shared package: the FSM state enum (dump_state_t) and the HDR_BYTE default constant, so the host-side decoder and bench reuse them.
- One natural sub-module: word_serializer. It takes a 32-bit load, presents 4 bytes LSB-first with the valid/ready handshake, accumulates the checksum, and flags the last byte.
- The top instance gates the soc RAM port A mux: uart_ram_wr_en has priority, then ram_dump_tx, then d_mux.

Test Plan:
1. RAM[0x10]=0x44332211, start_addr=0x10, word_cnt=1, uart_wr_ready=1 -> bytes A5,11,22,33,44,AA; done pulses once; busy falls in the same cycle as done.
2. RAM[0x3FFF]=0x00000001, RAM[0]=0x000000FF, start_addr=0x3FFF, word_cnt=2 -> ram_addr sequence 0x3FFF then 0x0000 (wrap); bytes A5,01,00,00,00,FF,00,00,00; checksum 0x00.
3. word_cnt=0, SEND_CKSUM=1 -> bytes A5,00, then done; ram_rd_en never asserts.
4. uart_wr_ready low for 5 cycles while the byte 0x22 is pending -> uart_wr_en stays 1, data stays 0x22, no duplicate or skipped byte; checksum still correct.
5. abort asserted after the 2nd data byte of a 4-word dump -> next cycle the FSM is in IDLE, busy=0, uart_wr_en=0, no done; a following start dumps correctly from the new start_addr.
6. rstb=0 for 1 cycle mid-SEND, and start pulsed during busy -> the extra start is ignored; after the reset edge all outputs are 0 and the FSM is in IDLE.

Source files
------------

// File: rtl/ram_dump_tx_pkg.sv
// Shared definitions for the RAM dump transmitter: FSM state encoding and
// the default frame header byte, reused by host-side decoders and benches.
package ram_dump_tx_pkg;

    typedef logic [2:0] dump_state_t;

    localparam dump_state_t StIdle = 3'd0;
    localparam dump_state_t StHdr  = 3'd1;
    localparam dump_state_t StRd   = 3'd2;
    localparam dump_state_t StRdw  = 3'd3;
    localparam dump_state_t StSend = 3'd4;
    localparam dump_state_t StCks  = 3'd5;
    localparam dump_state_t StFin  = 3'd6;

    localparam logic [7:0] HdrByteDefault = 8'hA5;

endpackage

// File: rtl/ram_dump_tx_if.sv
// RAM read port and UART TX byte port bundled for the dump transmitter.
// master = the dumper, slave = RAM mux / uart_mgr side.
interface ram_dump_tx_if #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned RAM_ADDR_LEN = 14
);

    logic                    ram_rd_en;
    logic [RAM_ADDR_LEN-1:0] ram_addr;
    logic [XLEN-1:0]         ram_rd_data;
    logic                    uart_wr_en;
    logic [7:0]              uart_wr_data;
    logic                    uart_wr_ready;

    modport master (
        output ram_rd_en,
        output ram_addr,
        input  ram_rd_data,
        output uart_wr_en,
        output uart_wr_data,
        input  uart_wr_ready
    );

    modport slave (
        input  ram_rd_en,
        input  ram_addr,
        output ram_rd_data,
        input  uart_wr_en,
        input  uart_wr_data,
        output uart_wr_ready
    );

endinterface

// File: rtl/ram_dump_tx_word_serializer.sv
// Splits a 32-bit word into 4 bytes, LSB first, and keeps the running
// 8-bit checksum of every data byte sent since the last clear.
module ram_dump_tx_word_serializer (
    input  logic        clk,
    input  logic        rstb,
    input  logic        clr,
    input  logic        load,
    input  logic [31:0] word,
    input  logic        advance,
    output logic [7:0]  tx_byte,
    output logic        last,
    output logic [7:0]  cksum
);

    logic [31:0] shift_q;
    logic [1:0]  byte_idx_q;
    logic [7:0]  cksum_q;

    // Clear at dump start, load per word, shift and accumulate per sent byte
    always_ff @(posedge clk) begin
        if (!rstb) begin
            shift_q    <= '0;
            byte_idx_q <= '0;
            cksum_q    <= '0;
        end else if (clr) begin
            shift_q    <= '0;
            byte_idx_q <= '0;
            cksum_q    <= '0;
        end else if (load) begin
            shift_q    <= word;
            byte_idx_q <= '0;
        end else if (advance) begin
            shift_q    <= {8'h00, shift_q[31:8]};
            cksum_q    <= cksum_q + shift_q[7:0];
            byte_idx_q <= byte_idx_q + 2'd1;
        end
    end

    assign tx_byte = shift_q[7:0];
    assign last    = (byte_idx_q == 2'd3);
    assign cksum   = cksum_q;

endmodule

// File: rtl/ram_dump_tx.sv
// Reads a range of RAM words and streams them to the UART TX byte port as
// a frame: header, 4 little-endian bytes per word, optional checksum.
module ram_dump_tx
    import ram_dump_tx_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned RAM_ADDR_LEN = 14,
    parameter logic [7:0]  HDR_BYTE     = HdrByteDefault,
    parameter bit          SEND_CKSUM   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  start,
    input  logic                  abort,
    input  logic [RAM_ADDR_LEN-1:0] start_addr,
    input  logic [RAM_ADDR_LEN:0] word_cnt,
    output logic                  busy,
    output logic                  done,
    ram_dump_tx_if.master         bus
);

    dump_state_t state_q, state_d, end_state;

    logic [RAM_ADDR_LEN-1:0] addr_q, addr_d;
    logic [RAM_ADDR_LEN-1:0] ram_addr_q;
    logic [RAM_ADDR_LEN:0]   remaining_q, remaining_d;
    logic                    gap_q;
    logic                    tx_state;
    logic                    xfer;
    logic                    start_ok;
    logic                    ser_load;
    logic                    ser_advance;
    logic                    ser_last;
    logic [7:0]              ser_byte;
    logic [7:0]              ser_cksum;
    logic [XLEN-1:0]         rd_word;

    assign end_state = SEND_CKSUM ? StCks : StFin;

    // gap_q forces one idle cycle after every transfer to suit the
    // registered ready on the uart_mgr side
    assign tx_state       = (state_q == StHdr) || (state_q == StSend) || (state_q == StCks);
    assign bus.uart_wr_en = tx_state && !gap_q;
    assign xfer           = bus.uart_wr_en && bus.uart_wr_ready;

    assign start_ok    = (state_q == StIdle) && start && !abort;
    assign ser_load    = (state_q == StRdw);
    assign ser_advance = (state_q == StSend) && xfer;

    assign busy = (state_q != StIdle) && (state_q != StFin);
    assign done = (state_q == StFin);

    // Address is driven live during RD and otherwise holds the last read address
    assign bus.ram_rd_en = (state_q == StRd);
    assign bus.ram_addr  = bus.ram_rd_en ? addr_q : ram_addr_q;
    assign rd_word       = bus.ram_rd_data;

    ram_dump_tx_word_serializer u_ser (
        .clk     (clk),
        .rstb    (rstb),
        .clr     (start_ok),
        .load    (ser_load),
        .word    (rd_word),
        .advance (ser_advance),
        .tx_byte (ser_byte),
        .last    (ser_last),
        .cksum   (ser_cksum)
    );

    // Byte presented to the UART depends on which part of the frame is active
    always_comb begin
        bus.uart_wr_data = 8'h00;
        case (state_q)
            StHdr:   bus.uart_wr_data = HDR_BYTE;
            StSend:  bus.uart_wr_data = ser_byte;
            StCks:   bus.uart_wr_data = ser_cksum;
            default: bus.uart_wr_data = 8'h00;
        endcase
    end

    // Frame sequencing; abort overrides any other transition, including completion
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        case (state_q)
            StIdle: begin
                if (start_ok) begin
                    addr_d      = start_addr;
                    remaining_d = word_cnt;
                    state_d     = StHdr;
                end
            end
            StHdr: begin
                if (xfer) begin
                    state_d = (remaining_q != '0) ? StRd : end_state;
                end
            end
            StRd:  state_d = StRdw;
            StRdw: state_d = StSend;
            StSend: begin
                if (xfer && ser_last) begin
                    addr_d      = addr_q + RAM_ADDR_LEN'(1);
                    remaining_d = remaining_q - (RAM_ADDR_LEN + 1)'(1);
                    state_d     = (remaining_d != '0) ? StRd : end_state;
                end
            end
            StCks: begin
                if (xfer) begin
                    state_d = StFin;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end
    end

    // State, counters and handshake gap register
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            ram_addr_q  <= '0;
            gap_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            gap_q       <= xfer;
            if (state_q == StRd) begin
                ram_addr_q <= addr_q;
            end
        end
    end

endmodule

// File: tb/tb_ram_dump_tx.sv
// Bench for ram_dump_tx: RAM model, UART sink with protocol monitor, and a
// frame reference model built from the dump rules with plain arithmetic.
module tb_ram_dump_tx;
    import ram_dump_tx_pkg::*;

    localparam int unsigned AW       = 14;
    localparam int          MemWords = 1 << AW;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   word_cnt = '0;
    logic          busy;
    logic          done;

    ram_dump_tx_if #(.XLEN(32), .RAM_ADDR_LEN(AW)) bus ();

    ram_dump_tx #(
        .XLEN         (32),
        .RAM_ADDR_LEN (AW),
        .HDR_BYTE     (HdrByteDefault),
        .SEND_CKSUM   (1'b1)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .start      (start),
        .abort      (abort),
        .start_addr (start_addr),
        .word_cnt   (word_cnt),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // RAM model: one-cycle read latency
    logic [31:0] mem [MemWords];
    always @(posedge clk) begin
        if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_addr];
    end

    // UART ready: forced level or random back-pressure
    bit   rand_ready  = 1'b0;
    logic ready_force = 1'b1;
    always @(negedge clk) begin
        #1;
        bus.uart_wr_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    // Monitor, sampling mid-cycle before the next rising edge
    logic [7:0]    rx_q[$];
    logic [AW-1:0] rd_addr_q[$];
    int            done_cnt = 0;
    int            proto_err = 0;
    int            done_busy_err = 0;
    logic          prev_xfer = 1'b0;
    logic          prev_en = 1'b0;
    logic          prev_busy = 1'b0;
    logic [7:0]    prev_data = 8'h00;
    always @(negedge clk) begin
        #2;
        if (bus.uart_wr_en && bus.uart_wr_ready) rx_q.push_back(bus.uart_wr_data);
        if (prev_xfer && bus.uart_wr_en) proto_err++;
        if (prev_en && !prev_xfer && bus.uart_wr_en && (bus.uart_wr_data != prev_data)) proto_err++;
        if (done) begin
            done_cnt++;
            if (busy || !prev_busy) done_busy_err++;
        end
        if (bus.ram_rd_en) rd_addr_q.push_back(bus.ram_addr);
        prev_xfer = bus.uart_wr_en && bus.uart_wr_ready;
        prev_en   = bus.uart_wr_en;
        prev_data = bus.uart_wr_data;
        prev_busy = busy;
    end

    // Reference frame: header, words little-endian with address wrap, checksum
    logic [7:0]    exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    function automatic void model_dump(input int a, input int cnt);
        int sum;
        sum = 0;
        exp_q.delete();
        exp_addr_q.delete();
        exp_q.push_back(HdrByteDefault);
        for (int i = 0; i < cnt; i++) begin
            int idx;
            idx = (a + i) % MemWords;
            exp_addr_q.push_back(AW'(idx));
            for (int b = 0; b < 4; b++) begin
                logic [7:0] v;
                v = mem[idx][8*b +: 8];
                exp_q.push_back(v);
                sum = (sum + int'(v)) % 256;
            end
        end
        exp_q.push_back(8'(sum));
    endfunction

    task automatic clear_mon();
        rx_q.delete();
        rd_addr_q.delete();
        done_cnt      = 0;
        proto_err     = 0;
        done_busy_err = 0;
    endtask

    task automatic do_start(input logic [AW-1:0] a, input logic [AW:0] c);
        @(negedge clk);
        start_addr = a;
        word_cnt   = c;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt != 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_size(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] got [6];
        string       nm [6];
        rstb = 1'b0;
        repeat (3) @(negedge clk);
        got = '{32'(busy), 32'(done), 32'(bus.ram_rd_en), 32'(bus.ram_addr),
                32'(bus.uart_wr_en), 32'(bus.uart_wr_data)};
        nm  = '{"busy", "done", "ram_rd_en", "ram_addr", "uart_wr_en", "uart_wr_data"};
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (got[i] !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_%s: got %0h want 0", nm[i], got[i]);
            end
        end
        rstb = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [7:0] lit [6];
        bit         ok;
        lit = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        mem[16]     = 32'h44332211;
        clear_mon();
        do_start(AW'(16), (AW + 1)'(1));
        wait_done(100, ok);
        repeat (3) @(negedge clk);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL single_done: no done pulse within budget, want one");
        end
        tests_run++;
        if (rx_q.size() != 6) begin
            tests_failed++;
            $display("FAIL single_len: got %0d bytes want 6", rx_q.size());
        end
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            tests_run++;
            if (rx_q[i] !== lit[i]) begin
                tests_failed++;
                $display("FAIL single_byte[%0d]: got %02h want %02h", i, rx_q[i], lit[i]);
            end
        end
        tests_run++;
        if (done_cnt != 1) begin
            tests_failed++;
            $display("FAIL single_done_cnt: got %0d want 1", done_cnt);
        end
        tests_run++;
        if (done_busy_err != 0 || proto_err != 0) begin
            tests_failed++;
            $display("FAIL single_protocol: got done/busy errs %0d, handshake errs %0d want 0/0",
                     done_busy_err, proto_err);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] lit [10];
        bit         ok;
        lit = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        mem[16'h3FFF] = 32'h00000001;
        mem[0]        = 32'h000000FF;
        clear_mon();
        do_start(AW'(16'h3FFF), (AW + 1)'(2));
        wait_done(200, ok);
        repeat (2) @(negedge clk);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL wrap_done: no done pulse within budget, want one");
        end
        tests_run++;
        if (rd_addr_q.size() != 2) begin
            tests_failed++;
            $display("FAIL wrap_rd_count: got %0d reads want 2", rd_addr_q.size());
        end else begin
            tests_run++;
            if (rd_addr_q[0] !== AW'(16'h3FFF) || rd_addr_q[1] !== AW'(0)) begin
                tests_failed++;
                $display("FAIL wrap_addr: got %04h,%04h want 3fff,0000", rd_addr_q[0], rd_addr_q[1]);
            end
        end
        tests_run++;
        if (rx_q.size() != 10) begin
            tests_failed++;
            $display("FAIL wrap_len: got %0d bytes want 10", rx_q.size());
        end
        for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
            tests_run++;
            if (rx_q[i] !== lit[i]) begin
                tests_failed++;
                $display("FAIL wrap_byte[%0d]: got %02h want %02h", i, rx_q[i], lit[i]);
            end
        end
    endtask

    task automatic test_zero_words();
        bit ok;
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        clear_mon();
        do_start(AW'($urandom_range(0, MemWords - 1)), '0);
        wait_done(50, ok);
        repeat (2) @(negedge clk);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL zero_done: no done pulse within budget, want one");
        end
        tests_run++;
        if (rx_q.size() != 2 || (rx_q.size() == 2 && (rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h00))) begin
            tests_failed++;
            $display("FAIL zero_bytes: got %0d bytes %p want A5,00", rx_q.size(), rx_q);
        end
        tests_run++;
        if (rd_addr_q.size() != 0) begin
            tests_failed++;
            $display("FAIL zero_rd_en: got %0d reads want 0", rd_addr_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] a;
        bit            ok;
        int            stall_err;
        a           = AW'($urandom_range(0, MemWords - 1));
        mem[a]      = 32'h44332211;
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        stall_err   = 0;
        model_dump(int'(a), 1);
        clear_mon();
        do_start(a, (AW + 1)'(1));
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.uart_wr_en && bus.uart_wr_data == 8'h22) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL bp_pending: byte 22 never presented, want it pending");
        end
        ready_force = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (!(bus.uart_wr_en && bus.uart_wr_data == 8'h22)) stall_err++;
        end
        ready_force = 1'b1;
        tests_run++;
        if (stall_err != 0) begin
            tests_failed++;
            $display("FAIL bp_hold: got %0d stalled cycles without en=1,data=22 want 0", stall_err);
        end
        wait_done(100, ok);
        repeat (2) @(negedge clk);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL bp_done: no done pulse within budget, want one");
        end
        tests_run++;
        if (rx_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL bp_len: got %0d bytes want %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            tests_run++;
            if (rx_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL bp_byte[%0d]: got %02h want %02h", i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_abort();
        logic [AW-1:0] a;
        int            c;
        bit            ok;
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        a = AW'($urandom_range(0, MemWords - 1));
        model_dump(int'(a), 4);
        clear_mon();
        do_start(a, (AW + 1)'(4));
        wait_size(3, 50, ok);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests_run++;
        if (!ok || busy !== 1'b0 || bus.uart_wr_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_idle: got reached=%0d busy=%0b en=%0b want 1,0,0",
                     ok, busy, bus.uart_wr_en);
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (done_cnt != 0 || rx_q.size() != 3) begin
            tests_failed++;
            $display("FAIL abort_quiet: got done=%0d bytes=%0d want 0,3", done_cnt, rx_q.size());
        end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            tests_run++;
            if (rx_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL abort_byte[%0d]: got %02h want %02h", i, rx_q[i], exp_q[i]);
            end
        end
        // start together with abort while idle must be dropped
        clear_mon();
        @(negedge clk);
        start_addr = a;
        word_cnt   = (AW + 1)'(1);
        start      = 1'b1;
        abort      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || rx_q.size() != 0) begin
            tests_failed++;
            $display("FAIL abort_start_idle: got busy=%0b bytes=%0d want 0,0", busy, rx_q.size());
        end
        a = AW'($urandom_range(0, MemWords - 1));
        c = $urandom_range(1, 3);
        model_dump(int'(a), c);
        clear_mon();
        do_start(a, (AW + 1)'(c));
        wait_done(200, ok);
        repeat (2) @(negedge clk);
        tests_run++;
        if (!ok || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL abort_restart_done: got done=%0d want 1", done_cnt);
        end
        tests_run++;
        if (rx_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL abort_restart_len: got %0d bytes want %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            tests_run++;
            if (rx_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL abort_restart_byte[%0d]: got %02h want %02h", i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] a;
        logic [31:0]   got [6];
        string         nm [6];
        bit            ok;
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        // extra start during a dump is ignored and not queued
        a = AW'($urandom_range(0, MemWords - 1));
        model_dump(int'(a), 2);
        clear_mon();
        do_start(a, (AW + 1)'(2));
        wait_size(2, 50, ok);
        do_start(a + AW'(100), (AW + 1)'(3));
        wait_done(200, ok);
        repeat (10) @(negedge clk);
        tests_run++;
        if (!ok || done_cnt != 1 || busy !== 1'b0 || rd_addr_q.size() != 2) begin
            tests_failed++;
            $display("FAIL busy_start: got done=%0d busy=%0b reads=%0d want 1,0,2",
                     done_cnt, busy, rd_addr_q.size());
        end
        tests_run++;
        if (rx_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL busy_start_len: got %0d bytes want %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            tests_run++;
            if (rx_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL busy_start_byte[%0d]: got %02h want %02h", i, rx_q[i], exp_q[i]);
            end
        end
        // reset in the middle of SEND
        a = AW'($urandom_range(0, MemWords - 1));
        clear_mon();
        do_start(a, (AW + 1)'(3));
        wait_size(3, 50, ok);
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        got = '{32'(busy), 32'(done), 32'(bus.ram_rd_en), 32'(bus.ram_addr),
                32'(bus.uart_wr_en), 32'(bus.uart_wr_data)};
        nm  = '{"busy", "done", "ram_rd_en", "ram_addr", "uart_wr_en", "uart_wr_data"};
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (got[i] !== 32'h0) begin
                tests_failed++;
                $display("FAIL midreset_%s: got %0h want 0", nm[i], got[i]);
            end
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done_cnt != 0 || rx_q.size() != 3) begin
            tests_failed++;
            $display("FAIL midreset_quiet: got busy=%0b done=%0d bytes=%0d want 0,0,3",
                     busy, done_cnt, rx_q.size());
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        int            c;
        bit            ok;
        rand_ready = 1'b1;
        for (int it = 0; it < 10; it++) begin
            a = ($urandom_range(0, 2) == 0) ? AW'(MemWords - $urandom_range(1, 4))
                                            : AW'($urandom_range(0, MemWords - 1));
            c = $urandom_range(0, 6);
            for (int k = 0; k < c; k++) mem[(int'(a) + k) % MemWords] = $urandom;
            model_dump(int'(a), c);
            clear_mon();
            do_start(a, (AW + 1)'(c));
            wait_done(400, ok);
            repeat (3) @(negedge clk);
            tests_run++;
            if (!ok || done_cnt != 1 || proto_err != 0 || done_busy_err != 0) begin
                tests_failed++;
                $display("FAIL rand%0d_ctrl: got done=%0d hs_err=%0d db_err=%0d want 1,0,0",
                         it, done_cnt, proto_err, done_busy_err);
            end
            tests_run++;
            if (rd_addr_q.size() != exp_addr_q.size()) begin
                tests_failed++;
                $display("FAIL rand%0d_reads: got %0d want %0d", it, rd_addr_q.size(),
                         exp_addr_q.size());
            end
            for (int i = 0; i < exp_addr_q.size() && i < rd_addr_q.size(); i++) begin
                tests_run++;
                if (rd_addr_q[i] !== exp_addr_q[i]) begin
                    tests_failed++;
                    $display("FAIL rand%0d_addr[%0d]: got %04h want %04h", it, i, rd_addr_q[i],
                             exp_addr_q[i]);
                end
            end
            tests_run++;
            if (rx_q.size() != exp_q.size()) begin
                tests_failed++;
                $display("FAIL rand%0d_len: got %0d bytes want %0d", it, rx_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
                tests_run++;
                if (rx_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL rand%0d_byte[%0d]: got %02h want %02h", it, i, rx_q[i],
                             exp_q[i]);
                end
            end
        end
        rand_ready = 1'b0;
    endtask

    initial begin
        bus.ram_rd_data = '0;
        for (int i = 0; i < MemWords; i++) mem[i] = $urandom;
        test_reset();
        test_single_word();
        test_wrap();
        test_zero_words();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end

endmodule
